watch_time_dp: RTL

//   Timekeeping datapath for watch mode, directly downstream of the watch control unit.

---
 rtl/watch_time_dp_if.sv | 36 +++
 rtl/watch_time_dp.sv | 112 +++++++++++
 2 files changed

// File: rtl/watch_time_dp_if.sv
// Bus between the watch control unit / display mux and the timekeeping datapath.
// Optional csec field present when WATCH_CSEC_EN is defined.
interface watch_time_dp_if;
  logic       stop;
  logic       sec_1;
  logic       sec_10;
  logic       min_1;
  logic       min_10;
  logic       hour_1;
  logic       hour_10;
  logic       btnU;
  logic       btnD;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       day_tick;
`ifdef WATCH_CSEC_EN
  logic [6:0] csec;
`endif

  modport master (
    output stop, sec_1, sec_10, min_1, min_10, hour_1, hour_10, btnU, btnD,
    input  sec, min, hour, day_tick
`ifdef WATCH_CSEC_EN
    , input csec
`endif
  );

  modport slave (
    input  stop, sec_1, sec_10, min_1, min_10, hour_1, hour_10, btnU, btnD,
    output sec, min, hour, day_tick
`ifdef WATCH_CSEC_EN
    , output csec
`endif
  );
endinterface

// File: rtl/watch_time_dp.sv
// Watch-mode hh:mm:ss counter with stopped-state digit adjust.
// Define WATCH_CSEC_EN to add a 1/100 s csec field that drives the seconds carry.
module watch_time_dp #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int INIT_HOUR = 12
) (
  input logic           clk,
  input logic           rst,
  watch_time_dp_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [4:0]    hour_q;
  logic          day_tick_q;

  logic [5:0]    sel;
  logic          step;
  logic          sec_en;
  logic          adj_ok;
  logic [6:0]    w7;
  logic [6:0]    sec_a7;
  logic [6:0]    min_a7;
  logic [6:0]    hour_a7;

  // Modular add/subtract of one digit weight; 7-bit operands cannot overflow
  // for any field value below its modulus.
  function automatic logic [6:0] adj_mod(input logic [6:0] f, input logic [6:0] w,
                                         input logic [6:0] m, input logic up);
    logic [6:0] t;
    t = up ? (f + w) : (f + m - w);
    return (t >= m) ? (t - m) : t;
  endfunction

  assign sel    = {bus.hour_10, bus.hour_1, bus.min_10, bus.min_1, bus.sec_10, bus.sec_1};
  assign step   = !bus.stop && (presc == PRE_LAST);
  assign adj_ok = bus.stop && $onehot(sel) && (bus.btnU ^ bus.btnD);
  assign w7     = (sel[1] | sel[3] | sel[5]) ? 7'd10 : 7'd1;

  always_comb begin
    sec_a7  = adj_mod({1'b0, sec_q},  w7, 7'd60, bus.btnU);
    min_a7  = adj_mod({1'b0, min_q},  w7, 7'd60, bus.btnU);
    hour_a7 = adj_mod({2'b0, hour_q}, w7, 7'd24, bus.btnU);
  end

`ifdef WATCH_CSEC_EN
  logic [6:0] csec_q;
  assign sec_en   = step && (csec_q == 7'd99);
  assign bus.csec = csec_q;
`else
  assign sec_en = step;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc      <= '0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'(INIT_HOUR);
      day_tick_q <= 1'b0;
`ifdef WATCH_CSEC_EN
      csec_q     <= 7'd0;
`endif
    end else begin
      day_tick_q <= 1'b0;
      // Stop clears the prescaler so a resume always waits a full period.
      if (bus.stop || step) presc <= '0;
      else                  presc <= presc + PW'(1);

      if (adj_ok) begin
        if (sel[1:0] != 2'b00) sec_q  <= sec_a7[5:0];
        if (sel[3:2] != 2'b00) min_q  <= min_a7[5:0];
        if (sel[5:4] != 2'b00) hour_q <= hour_a7[4:0];
`ifdef WATCH_CSEC_EN
        csec_q <= 7'd0;
`endif
      end else if (step) begin
`ifdef WATCH_CSEC_EN
        csec_q <= (csec_q == 7'd99) ? 7'd0 : csec_q + 7'd1;
`endif
        if (sec_en) begin
          if (sec_q == 6'd59) begin
            sec_q <= 6'd0;
            if (min_q == 6'd59) begin
              min_q <= 6'd0;
              if (hour_q == 5'd23) begin
                hour_q     <= 5'd0;
                day_tick_q <= 1'b1;
              end else begin
                hour_q <= hour_q + 5'd1;
              end
            end else begin
              min_q <= min_q + 6'd1;
            end
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end
      end
    end
  end

  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hour     = hour_q;
  assign bus.day_tick = day_tick_q;

endmodule
